// File: rtl/comb_vector_driver.sv
// comb_vector_driver: serial-load / parallel-apply / serial-unload driver
// for one register-cut combinational block on the fault-injection host path.
//
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   start     in   1      begin one vector cycle (sampled only in IDLE)
//   si        in   1      serial stimulus, LSB first
//   vec_out   out  IN_W   parallel stimulus to the cut inputs
//   resp_in   in   OUT_W  parallel response from the cut outputs
//   so        out  1      serial response, LSB first
//   so_valid  out  1      so carries a response bit
//   busy      out  1      high in every state except IDLE
//   done      out  1      one-cycle completion pulse
// Optional (macro COMB_DRV_GOLDEN_CMP_EN):
//   golden    in   OUT_W  expected response, sampled with resp_in
//   mismatch  out  1      last capture differed from golden
//   err_cnt   out  16     saturating count of mismatching captures
module comb_vector_driver #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             si,
    output logic [IN_W-1:0]  vec_out,
    input  logic [OUT_W-1:0] resp_in,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
`ifdef COMB_DRV_GOLDEN_CMP_EN
    input  logic [OUT_W-1:0] golden,
    output logic             mismatch,
    output logic [15:0]      err_cnt,
`endif
    output logic             done
);

    localparam int MAX_A = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int MAX_N = (MAX_A > SETTLE) ? MAX_A : SETTLE;
    localparam int CW    = $clog2(MAX_N + 1);

    localparam logic [CW-1:0] IN_LAST  = CW'(IN_W - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_W - 1);

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("comb_vector_driver: SETTLE must be >= 1");
        end
        if (IN_W < 1 || OUT_W < 1) begin : g_bad_width
            $error("comb_vector_driver: IN_W and OUT_W must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        APPLY,
        CAPTURE,
        SHIFT_OUT,
        DONE_ST
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IN_W-1:0]  in_sreg;
    logic [OUT_W-1:0] out_sreg;
    logic [IN_W-1:0]  in_next;

    // New bit enters at the MSB so the first bit ends up in bit 0.
    assign in_next = (in_sreg >> 1) | (IN_W'(si) << (IN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_sreg  <= '0;
            out_sreg <= '0;
            vec_out  <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef COMB_DRV_GOLDEN_CMP_EN
            mismatch <= 1'b0;
            err_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT_IN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT_IN: begin
                    in_sreg <= in_next;
                    if (cnt == IN_LAST) begin
                        vec_out <= in_next;
                        state   <= APPLY;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                APPLY: begin
                    if (cnt == SET_LAST) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    // Bit 0 goes straight to so; the rest waits in out_sreg.
                    out_sreg <= resp_in >> 1;
                    so       <= resp_in[0];
                    so_valid <= 1'b1;
                    state    <= SHIFT_OUT;
                    cnt      <= '0;
`ifdef COMB_DRV_GOLDEN_CMP_EN
                    mismatch <= (resp_in != golden);
                    if (resp_in != golden && err_cnt != 16'hFFFF)
                        err_cnt <= err_cnt + 16'd1;
`endif
                end
                SHIFT_OUT: begin
                    if (cnt == OUT_LAST) begin
                        so       <= 1'b0;
                        so_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE_ST;
                    end else begin
                        so       <= out_sreg[0];
                        out_sreg <= out_sreg >> 1;
                        cnt      <= cnt + 1'b1;
                    end
                end
                DONE_ST: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
